// File: rtl/dca_cmd_issuer.sv
// Command issuer behind the DCA mask scheduler: tracks (row, col), queues A/B issue
// strobes as {kind,row,col} commands and throttles the scheduler so nothing is lost.
module dca_cmd_issuer #(
  parameter int ROW_COUNT       = 8,
  parameter int COL_POSITIONS   = 9,
  parameter int ROW_INDEX_WIDTH = 3,
  parameter int COL_INDEX_WIDTH = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rstnn,
  input  logic                       i_init,
  input  logic                       i_col_step,
  input  logic                       i_row_step,
  input  logic                       i_issue_a,
  input  logic                       i_issue_b,
  input  logic                       i_frame_done,
  output logic                       o_sched_enable,
  output logic                       o_cmd_valid,
  input  logic                       i_cmd_ready,
  output logic                       o_cmd_kind,
  output logic [ROW_INDEX_WIDTH-1:0] o_cmd_row,
  output logic [COL_INDEX_WIDTH-1:0] o_cmd_col,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int ENTRY_W = 1 + ROW_INDEX_WIDTH + COL_INDEX_WIDTH;
  localparam int PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  logic [ROW_INDEX_WIDTH-1:0] r_row;
  logic [COL_INDEX_WIDTH-1:0] r_col;
  logic [ENTRY_W-1:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_done_pending;
  logic                       r_done;

  logic                       w_en;
  logic                       w_start;
  logic                       w_push_a;
  logic                       w_push_b;
  logic                       w_pop;
  logic [ENTRY_W-1:0]         w_entry_a;
  logic [ENTRY_W-1:0]         w_entry_b;
  logic [PTR_W-1:0]           w_wr_ptr_b;
  logic [PTR_W-1:0]           w_wr_ptr_nxt;
  logic [CNT_W-1:0]           w_count_nxt;
  logic                       w_dp_pre;
  logic                       w_done_nxt;
  logic [ROW_INDEX_WIDTH-1:0] w_row_nxt;
  logic [COL_INDEX_WIDTH-1:0] w_col_nxt;

  // Strobe qualification, queue bookkeeping and done detection
  always_comb begin
    w_en         = (r_count <= CNT_W'(FIFO_DEPTH - 2));
    w_start      = w_en & i_init;
    w_push_a     = w_en & ~i_init & i_issue_a;
    w_push_b     = w_en & ~i_init & i_issue_b;
    w_pop        = (r_count != '0) & i_cmd_ready;
    w_entry_a    = {1'b0, r_row, r_col};
    // B refers to the previous column; col 0 wraps modulo 2^COL_INDEX_WIDTH on purpose
    w_entry_b    = {1'b1, r_row, r_col - COL_INDEX_WIDTH'(1)};
    w_wr_ptr_b   = w_push_a ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_wr_ptr_nxt = w_push_b ? ptr_inc(w_wr_ptr_b) : w_wr_ptr_b;
    w_count_nxt  = r_count + CNT_W'(w_push_a) + CNT_W'(w_push_b) - CNT_W'(w_pop);
    if (w_start) begin
      w_dp_pre = 1'b0;
    end else if (w_en & i_frame_done) begin
      w_dp_pre = 1'b1;
    end else begin
      w_dp_pre = r_done_pending;
    end
    // an empty next-state count implies no push this cycle
    w_done_nxt = w_dp_pre & (w_count_nxt == '0);
  end

  // Next position: init beats row_step beats col_step
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_start) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (w_en & i_row_step) begin
      w_col_nxt = '0;
      if (r_row == ROW_INDEX_WIDTH'(ROW_COUNT - 1)) begin
        w_row_nxt = '0;
      end else begin
        w_row_nxt = r_row + ROW_INDEX_WIDTH'(1);
      end
    end else if (w_en & i_col_step) begin
      if (r_col == COL_INDEX_WIDTH'(COL_POSITIONS - 1)) begin
        w_col_nxt = '0;
      end else begin
        w_col_nxt = r_col + COL_INDEX_WIDTH'(1);
      end
    end else begin
      w_row_nxt = r_row;
      w_col_nxt = r_col;
    end
  end

  // State registers: position, queue pointers/count and done tracking
  always_ff @(posedge i_clk or negedge i_rstnn) begin
    if (!i_rstnn) begin
      r_row          <= '0;
      r_col          <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_done_pending <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_row          <= w_row_nxt;
      r_col          <= w_col_nxt;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
      r_count        <= w_count_nxt;
      r_done_pending <= w_dp_pre & ~w_done_nxt;
      r_done         <= w_done_nxt;
    end
  end

  // Queue storage: A lands first, B in the following slot
  always_ff @(posedge i_clk or negedge i_rstnn) begin
    if (!i_rstnn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_a) begin
        r_mem[r_wr_ptr] <= w_entry_a;
      end
      if (w_push_b) begin
        r_mem[w_wr_ptr_b] <= w_entry_b;
      end
    end
  end

  assign o_sched_enable = w_en;
  assign o_cmd_valid    = (r_count != '0);
  assign o_cmd_kind     = r_mem[r_rd_ptr][ENTRY_W-1];
  assign o_cmd_row      = r_mem[r_rd_ptr][COL_INDEX_WIDTH +: ROW_INDEX_WIDTH];
  assign o_cmd_col      = r_mem[r_rd_ptr][COL_INDEX_WIDTH-1:0];
  assign o_busy         = r_done_pending | (r_count != '0);
  assign o_done         = r_done;

endmodule

// File: tb/tb_dca_cmd_issuer.sv
// Self-checking bench for dca_cmd_issuer: directed scenarios against hand-derived
// constants, then random traffic against a queue-based reference model.
module tb_dca_cmd_issuer;

  logic       clk = 1'b0;
  logic       rstnn;
  logic       init, col_step, row_step, issue_a, issue_b, frame_done, cmd_ready;
  logic       sched_enable, cmd_valid, cmd_kind, busy, done;
  logic [2:0] cmd_row;
  logic [3:0] cmd_col;
  logic [7:0] head;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [7:0] m_q[$];
  int         m_row, m_col;
  bit         m_dp, m_done;

  always #5 clk = ~clk;
  assign head = {cmd_kind, cmd_row, cmd_col};

  dca_cmd_issuer #(
    .ROW_COUNT(8), .COL_POSITIONS(9), .ROW_INDEX_WIDTH(3), .COL_INDEX_WIDTH(4), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rstnn(rstnn), .i_init(init), .i_col_step(col_step), .i_row_step(row_step),
    .i_issue_a(issue_a), .i_issue_b(issue_b), .i_frame_done(frame_done),
    .o_sched_enable(sched_enable), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_kind(cmd_kind), .o_cmd_row(cmd_row), .o_cmd_col(cmd_col), .o_busy(busy), .o_done(done)
  );

  // Drive one cycle of inputs, advance the model by the same cycle, sample at negedge.
  task automatic step(input bit ini, cs, rs, ia, ib, fd, rdy);
    bit en;
    init = ini; col_step = cs; row_step = rs; issue_a = ia; issue_b = ib;
    frame_done = fd; cmd_ready = rdy;
    en = (4 - m_q.size()) >= 2;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (en && ini) begin
      m_row = 0; m_col = 0; m_dp = 0;
    end else if (en) begin
      if (ia) m_q.push_back({1'b0, 3'(m_row), 4'(m_col)});
      if (ib) m_q.push_back({1'b1, 3'(m_row), 4'((m_col + 15) % 16)});
      if (fd) m_dp = 1;
      if (rs) begin
        m_col = 0; m_row = (m_row + 1) % 8;
      end else if (cs) begin
        m_col = (m_col + 1) % 9;
      end
    end
    m_done = m_dp && (m_q.size() == 0);
    if (m_done) m_dp = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstnn = 1'b0;
    init = 0; col_step = 0; row_step = 0; issue_a = 0; issue_b = 0; frame_done = 0; cmd_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    m_q.delete(); m_row = 0; m_col = 0; m_dp = 0; m_done = 0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (sched_enable !== 1'b1) $display("FAIL reset_sched_enable: got %b want 1", sched_enable); else n_pass++;
      n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
      n_checks++; if (head !== 8'h00) $display("FAIL reset_head: got %h want 00", head); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
      step(0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_position();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0, 0);
    n_checks++; if (sched_enable !== 1'b0) $display("FAIL pos_sched_full: got %b want 0", sched_enable); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b1 || head !== 8'h00) $display("FAIL pos_cmd0: got v=%b %h want v=1 00", cmd_valid, head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (head !== 8'h03) $display("FAIL pos_cmd1: got %h want 03", head); else n_pass++;
    n_checks++; if (sched_enable !== 1'b1) $display("FAIL pos_sched_reopen: got %b want 1", sched_enable); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (head !== 8'h82) $display("FAIL pos_cmd2: got %h want 82", head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL pos_drained: got %b want 0", cmd_valid); else n_pass++;
    step(0, 0, 0, 1, 0, 0, 0);
    n_checks++; if (head !== 8'h04) $display("FAIL pos_col4: got %h want 04", head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_row_wrap();
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    n_checks++; if (cmd_valid !== 1'b1 || head !== 8'h10) $display("FAIL wrap_rowcol: got v=%b %h want v=1 10", cmd_valid, head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (7) step(0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    n_checks++; if (cmd_valid !== 1'b1 || head !== 8'h00) $display("FAIL wrap_row0: got v=%b %h want v=1 00", cmd_valid, head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL wrap_drained: got %b want 0", cmd_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 1, 0, 0, 0);
      n_checks++; if (sched_enable !== (k < 2)) $display("FAIL bp_sched_%0d: got %b want %b", k, sched_enable, (k < 2)); else n_pass++;
      n_checks++; if (head !== 8'h00) $display("FAIL bp_head_%0d: got %h want 00", k, head); else n_pass++;
    end
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (head !== 8'h01 || sched_enable !== 1'b1) $display("FAIL bp_pop1: got %h en=%b want 01 en=1", head, sched_enable); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (head !== 8'h02) $display("FAIL bp_pop2: got %h want 02", head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL bp_no_dup: got %b want 0", cmd_valid); else n_pass++;
    step(0, 0, 0, 1, 0, 0, 0);
    n_checks++; if (head !== 8'h03) $display("FAIL bp_ignored_steps: got %h want 03", head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_done();
    int pulses;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    n_checks++; if (busy !== 1'b1 || done !== 1'b0 || head !== 8'h01) $display("FAIL done_pending: got busy=%b done=%b %h want 1 0 01", busy, done, head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0) $display("FAIL done_pulse: got done=%b busy=%b v=%b want 1 0 0", done, busy, cmd_valid); else n_pass++;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      if (done === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL done_once: got %0d extra pulses want 0", pulses); else n_pass++;
    step(0, 0, 0, 0, 0, 1, 1);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL done_empty: got done=%b busy=%b want 1 0", done, busy); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (done !== 1'b0) $display("FAIL done_clear: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_mid_init();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0);
    n_checks++; if (sched_enable !== 1'b1 || head !== 8'h00) $display("FAIL init_drop: got en=%b %h want 1 00", sched_enable, head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (head !== 8'h01) $display("FAIL init_keep: got %h want 01", head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL init_drained: got %b want 0", cmd_valid); else n_pass++;
    step(0, 0, 0, 1, 0, 0, 0);
    n_checks++; if (head !== 8'h00) $display("FAIL init_restart: got %h want 00", head); else n_pass++;
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(31) == 0, $urandom_range(1) == 0, $urandom_range(7) == 0,
           $urandom_range(1) == 0, $urandom_range(2) == 0, $urandom_range(15) == 0,
           $urandom_range(2) != 0);
      n_checks++; if (sched_enable !== ((4 - m_q.size()) >= 2)) $display("FAIL rnd_sched_%0d: got %b want %b", k, sched_enable, ((4 - m_q.size()) >= 2)); else n_pass++;
      n_checks++; if (cmd_valid !== (m_q.size() != 0)) $display("FAIL rnd_valid_%0d: got %b want %b", k, cmd_valid, (m_q.size() != 0)); else n_pass++;
      n_checks++; if (busy !== (m_dp || m_q.size() != 0)) $display("FAIL rnd_busy_%0d: got %b want %b", k, busy, (m_dp || m_q.size() != 0)); else n_pass++;
      n_checks++; if (done !== m_done) $display("FAIL rnd_done_%0d: got %b want %b", k, done, m_done); else n_pass++;
      if (m_q.size() != 0) begin
        n_checks++; if (head !== m_q[0]) $display("FAIL rnd_head_%0d: got %h want %h", k, head, m_q[0]); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_position();
    test_row_wrap();
    test_backpressure();
    test_done();
    test_mid_init();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dca_cmd_issuer.md
# dca_cmd_issuer

Downstream companion to the DCA row/column mask scheduler. It consumes the scheduler's per-position strobes: column step, row step, A-issue, B-issue and frame-done. It tracks the current (row, column) position and converts each issue strobe into a queued `{kind, row, col}` command on a valid/ready stream. It throttles the scheduler through `sched_enable`, so no strobe is ever lost when the command consumer stalls.

## Interface
- ROW_COUNT, 8, rows scanned per frame; equals the scheduler's row-mask width.
- COL_POSITIONS, 9, column positions per row; equals the column-mask width + 1.
- ROW_INDEX_WIDTH, 3, width of row index; must satisfy 2^w ≥ ROW_COUNT.
- COL_INDEX_WIDTH, 4, width of column index; must satisfy 2^w ≥ COL_POSITIONS.
- FIFO_DEPTH, 4, command queue entries; must be ≥ 2.

Ports:
- clk  in  1  clock.
- rstnn  in  1  reset, asynchronous, active-low.
- init  in  1  start of frame; clears position and done-pending state.
- col_step  in  1  advance column within the current row.
- row_step  in  1  last column of row; column←0, row advances.
- issue_a  in  1  issue an A command at the current column.
- issue_b  in  1  issue a B command at the current column − 1.
- frame_done  in  1  scheduler has finished the frame.
- sched_enable  out  1  clock-enable returned to the scheduler.
- cmd_valid  out  1  queue head valid.
- cmd_ready  in  1  consumer accepts the head.
- cmd_kind  out  1  0 = A, 1 = B.
- cmd_row  out  ROW_INDEX_WIDTH  row of the head command.
- cmd_col  out  COL_INDEX_WIDTH  column of the head command.
- busy  out  1  done pending, or queue not empty.
- done  out  1  one-cycle pulse once the frame has finished and the queue has drained.

## Operation
- Qualification:
  - sched_enable = (FIFO_DEPTH − count ≥ 2), computed from registered count only; there is no combinational path from cmd_ready.
  - All strobe inputs (init, col_step, row_step, issue_a, issue_b, frame_done) are acted on only in cycles where sched_enable = 1; otherwise they are ignored.
- Position registers row_idx and col_idx:
  - init: row_idx←0, col_idx←0, done_pending←0. Issue strobes and frame_done in the same cycle are ignored; init has top priority.
  - row_step (with or without col_step): col_idx←0; row_idx←row_idx+1, wrapping ROW_COUNT−1→0.
  - col_step alone: col_idx←col_idx+1, wrapping COL_POSITIONS−1→0.
- Command capture uses the pre-step indices of the same cycle:
  - issue_a pushes {0, row_idx, col_idx}.
  - issue_b pushes {1, row_idx, col_idx−1}; col_idx = 0 yields col_idx−1 modulo 2^COL_INDEX_WIDTH, which is a legal scheduler-error case and is passed through.
  - issue_a and issue_b together push two entries, A first then B.
- Queue:
  - Circular FIFO with up to 2 pushes and 1 pop per cycle.
  - Pop occurs when cmd_valid & cmd_ready.
  - Push and pop in the same cycle are allowed; count updates by pushes − pop.
  - cmd_valid = (count ≠ 0); cmd_kind, cmd_row and cmd_col come from the head entry.
  - Overflow is impossible by construction of sched_enable.
- Done:
  - Qualified frame_done sets done_pending.
  - done pulses for one cycle when done_pending = 1, count = 0 and no push occurs that cycle; done_pending clears in the same cycle.
  - busy = done_pending | (count ≠ 0).
- init mid-frame: position and done_pending are cleared; queued commands are kept and keep draining normally.

## Timing
- Reset values: sched_enable 1 (count 0); cmd_valid 0; cmd_kind 0; cmd_row 0; cmd_col 0; busy 0; done 0. Storage, indices, count and done_pending are all 0.
- Push-to-visible latency is 1 cycle: an issue in cycle N gives cmd_valid = 1 in N+1 when the queue was empty.
- Pop is visible next cycle: head advances and count drops at the clock edge after the handshake.
- sched_enable reflects the count after the last clock edge. With DEPTH = 4 it drops as soon as count = 3, and rises the cycle after a pop brings count ≤ 2.
- done rises at the earliest 1 cycle after frame_done when the queue is empty; otherwise it rises 1 cycle after the pop that empties the queue.
- No output depends combinationally on any input except cmd_valid's consumer-side use; all outputs are registered or decoded from registered state.

## Test plan
- Reset then idle, with cmd_ready = 1: all outputs hold their reset values; sched_enable = 1.
- Position tracking:
  - Stimulus: init; issue_a with col_step at col 0; col_step ×2; issue_a with issue_b and col_step.
  - Required: commands {A,0,0}, {A,0,3}, {B,0,2} in that order; col_idx = 4 afterwards.
- Row wrap:
  - Stimulus: with ROW_COUNT = 8, apply 8 row_steps, then issue_a.
  - Required: command {A,0,0}; a row_step coinciding with col_step leaves col_idx = 0.
- Backpressure:
  - Stimulus: hold cmd_ready = 0; issue_a once per enabled cycle.
  - Required: sched_enable falls when count reaches 3; strobes while sched_enable = 0 are ignored; release cmd_ready gives 3 commands, in order, with no loss or duplication.
- Done ordering:
  - Stimulus: frame_done while 2 commands are queued and cmd_ready = 1.
  - Required: done pulses exactly once, 1 cycle after the second pop; busy falls in the same cycle.
- Mid-frame init:
  - Stimulus: init with queued entries and an issue_a in the same cycle.
  - Required: issue_a is dropped; queued entries still drain unchanged; the next issue_a yields {A,0,0}.
